// File: rtl/chunked_adder_ctrl.sv
// chunked_adder_ctrl: wide add sequenced over one CHUNK_W-bit ripple slice, LSB chunk first,
// with a registered carry between chunks and valid/ready handshakes on both sides.
module chunked_adder_ctrl #(
    parameter int OP_W    = 16,
    parameter int CHUNK_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in1,
    input  logic [OP_W-1:0] in2,
    input  logic            Cin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] Sum,
    output logic            Cout,
    output logic            busy
);
    localparam int N     = OP_W / CHUNK_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK_W < 1 || (OP_W % CHUNK_W) != 0) begin : g_bad_params
            $error("chunked_adder_ctrl: OP_W must be a positive multiple of CHUNK_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [OP_W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               carry_q, carry_d, cout_q, cout_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CHUNK_W:0]   chunk_sum;
    int                 base;

    assign base      = int'(idx_q) * CHUNK_W;
    assign chunk_sum = {1'b0, a_q[base +: CHUNK_W]} + {1'b0, b_q[base +: CHUNK_W]}
                     + (CHUNK_W+1)'(carry_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                a_d     = in1;
                b_d     = in2;
                carry_d = Cin;
                idx_d   = '0;
            end
            RUN: begin
                sum_d[base +: CHUNK_W] = chunk_sum[CHUNK_W-1:0];
                carry_d = chunk_sum[CHUNK_W];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N-1)) begin
                    cout_d  = chunk_sum[CHUNK_W];
                    state_d = DONE;
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign Sum       = sum_q;
    assign Cout      = cout_q;
endmodule

// File: tb/tb_chunked_adder_ctrl.sv
// tb_chunked_adder_ctrl: directed vector table plus hand-written multi-cycle sequences
// for the 16/4 sequencer and a 16/16 single-chunk instance.
module tb_chunked_adder_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, Cin = 1'b0;
    logic [15:0] in1 = '0, in2 = '0;
    logic        in_ready, out_valid, Cout, busy;
    logic [15:0] Sum;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b0, Cin1 = 1'b0;
    logic [15:0] in1_1 = '0, in2_1 = '0;
    logic        in_ready1, out_valid1, Cout1, busy1;
    logic [15:0] Sum1;

    int checks = 0, errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
    } vec_t;
    vec_t vecs[7];

    chunked_adder_ctrl #(.OP_W(16), .CHUNK_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .busy(busy)
    );

    chunked_adder_ctrl #(.OP_W(16), .CHUNK_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in1(in1_1), .in2(in2_1), .Cin(Cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .Sum(Sum1), .Cout(Cout1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 16/4 instance; stall = DONE cycles with out_ready low.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input int stall, output logic [15:0] s, output logic co, output int lat);
        int n = 0;
        int bad = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_before_op", {31'b0, in_ready}, 1);
        in1 = a; in2 = b; Cin = ci; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (in_ready || !busy) bad++;
            tick();
            lat++;
        end
        if (in_ready || !busy) bad++;
        s = Sum;
        co = Cout;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (!out_valid || in_ready || Sum !== s || Cout !== co) bad++;
        end
        check("ready_low_hold", bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("no_duplicate", {30'b0, out_valid, in_ready}, 32'h1);
    endtask

    initial begin
        logic [15:0] s, es;
        logic        co, eco;
        logic [15:0] ra, rb;
        logic        rc;
        int          lat, n;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};

        #12;
        check("rst_in_ready",  {31'b0, in_ready},  1);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_busy",      {31'b0, busy},      0);
        check("rst_sum",       Sum,                0);
        check("rst_cout",      {31'b0, Cout},      0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, 0, s, co, lat);
            check($sformatf("vec%0d_lat", i), lat, 4);
            check($sformatf("vec%0d_sum", i), s, vecs[i].s);
            check($sformatf("vec%0d_cout", i), {31'b0, co}, {31'b0, vecs[i].co});
        end

        // Backpressure: result held while new in_valid pulses are ignored.
        in1 = 16'h0102; in2 = 16'h0304; Cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_lat", n, 4);
        in1 = 16'h1111; in2 = 16'h2222; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", {Sum, 6'b0, out_valid, in_ready, Cout}, {16'h0406, 6'b0, 3'b100});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", {30'b0, out_valid, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
        check("bp_next_accept", {31'b0, busy}, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_next_sum", {Sum, 15'b0, Cout}, {16'h3333, 16'h0});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a run abandons the operation.
        in1 = 16'hAAAA; in2 = 16'h5555; Cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrun_rst", {Sum, 12'b0, in_ready, out_valid, busy, Cout}, {16'h0000, 16'h0008});
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op(16'h0001, 16'h0001, 1'b0, 0, s, co, lat);
        check("post_rst_sum", {Sum, 15'b0, co}, {s, 16'h0});
        check("post_rst_val", {s, 15'b0, co}, {16'h0002, 16'h0});

        // Single-chunk instance: one RUN cycle, registered full add.
        in1_1 = 16'h8000; in2_1 = 16'h8000; Cin1 = 1'b1; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            tick();
            n++;
        end
        check("n1_lat", n, 1);
        check("n1_result", {Sum1, 15'b0, Cout1}, {16'h0001, 16'h1});
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("n1_release", {30'b0, out_valid1, in_ready1}, 32'h1);

        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            {eco, es} = 17'(ra) + 17'(rb) + 17'(rc);
            do_op(ra, rb, rc, int'($urandom_range(0, 3)), s, co, lat);
            check($sformatf("rnd%0d_lat", i), lat, 4);
            check($sformatf("rnd%0d_res", i), {s, 15'b0, co}, {es, 15'b0, eco});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
